// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FP datapath: field widths, constants,
// the divider state encoding and operand classification helpers.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;
  localparam int DIV_STEPS = MAN_W + 3;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_ROUND,
    S_SPECIAL
  } state_t;

  // Exponent 0 counts as zero: denormal inputs are flushed.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/mant_div_seq.sv
// Restoring mantissa divider: one quotient bit per clock over 26 steps,
// producing q = floor(ma * 2^25 / mb) plus a sticky flag for the remainder.
module mant_div_seq
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MAN_W:0]   ma,
  input  logic [MAN_W:0]   mb,
  output logic [MAN_W+2:0] q,
  output logic             sticky,
  output logic             valid
);

  logic [MAN_W+1:0] rem_reg;
  logic [MAN_W+1:0] rem_sub;
  logic [MAN_W+1:0] rem_sel;
  logic [MAN_W:0]   mb_reg;
  logic [MAN_W+2:0] q_reg;
  logic [4:0]       cnt_reg;
  logic             run_reg;
  logic             valid_reg;
  logic             ge;

  always_comb begin
    ge      = rem_reg >= {1'b0, mb_reg};
    rem_sub = rem_reg - {1'b0, mb_reg};
    rem_sel = ge ? rem_sub : rem_reg;
  end

  // After a subtract the remainder is below mb, so the shift never loses a bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg   <= '0;
      mb_reg    <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      run_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (load) begin
      rem_reg   <= {1'b0, ma};
      mb_reg    <= mb;
      q_reg     <= '0;
      cnt_reg   <= '0;
      run_reg   <= 1'b1;
      valid_reg <= 1'b0;
    end else if (run_reg) begin
      q_reg   <= {q_reg[MAN_W+1:0], ge};
      rem_reg <= {rem_sel[MAN_W:0], 1'b0};
      cnt_reg <= cnt_reg + 5'd1;
      if (cnt_reg == 5'(DIV_STEPS - 1)) begin
        run_reg   <= 1'b0;
        valid_reg <= 1'b1;
      end
    end
  end

  assign q      = q_reg;
  assign sticky = |rem_reg;
  assign valid  = valid_reg;

endmodule

// File: rtl/float_divider.sv
// Sequential binary32 divider a / b: special-case bypass, 26-cycle restoring
// mantissa divide, normalise, round-to-nearest-even with flush-to-zero.
module float_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero
);

  state_t             state_reg, state_next;
  logic               sign_reg;
  logic signed [9:0]  exp_reg;
  logic [4:0]         cnt_reg;
  logic [23:0]        man_reg;
  logic               guard_reg;
  logic               sticky_reg;
  logic [31:0]        spec_res_reg;
  logic               spec_dbz_reg;
  logic [31:0]        result_reg;
  logic               done_reg;
  logic               busy_reg;
  logic               dbz_reg;

  logic               sign_in;
  logic signed [9:0]  exp_in;
  logic               special;
  logic [31:0]        spec_res;
  logic               spec_dbz;

  logic               div_load;
  logic [25:0]        div_q;
  logic               div_sticky;
  logic               div_valid;

  logic               round_inc;
  logic [24:0]        man_sum;
  logic [23:0]        man_rnd;
  logic signed [9:0]  exp_rnd;
  logic [31:0]        round_res;

  assign sign_in = a[31] ^ b[31];
  assign exp_in  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;

  // Special cases in priority order; anything left goes through the divider.
  always_comb begin
    special  = 1'b1;
    spec_dbz = 1'b0;
    spec_res = QNAN;
    if (is_nan(a) || is_nan(b)) begin
      spec_res = QNAN;
    end else if ((is_inf(a) && is_inf(b)) || (is_zero(a) && is_zero(b))) begin
      spec_res = QNAN;
    end else if (is_inf(a)) begin
      spec_res = POS_INF | {sign_in, 31'd0};
    end else if (is_inf(b)) begin
      spec_res = {sign_in, 31'd0};
    end else if (is_zero(b)) begin
      spec_res = POS_INF | {sign_in, 31'd0};
      spec_dbz = 1'b1;
    end else if (is_zero(a)) begin
      spec_res = {sign_in, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  assign div_load = (state_reg == S_IDLE) && start && !special;

  mant_div_seq u_mant_div (
    .clk    (clk),
    .rst    (rst),
    .load   (div_load),
    .ma     ({1'b1, a[22:0]}),
    .mb     ({1'b1, b[22:0]}),
    .q      (div_q),
    .sticky (div_sticky),
    .valid  (div_valid)
  );

  always_comb begin
    round_inc = guard_reg & (sticky_reg | man_reg[0]);
    man_sum   = {1'b0, man_reg} + {24'd0, round_inc};
    man_rnd   = man_sum[23:0];
    exp_rnd   = exp_reg;
    if (man_sum[24]) begin
      man_rnd = 24'h800000;
      exp_rnd = exp_reg + 10'sd1;
    end
    if (exp_rnd >= 10'sd255) begin
      round_res = POS_INF | {sign_reg, 31'd0};
    end else if (exp_rnd <= 10'sd0) begin
      round_res = {sign_reg, 31'd0};
    end else begin
      round_res = {sign_reg, exp_rnd[7:0], man_rnd[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = special ? S_SPECIAL : S_DIV;
      S_DIV:     if (cnt_reg == 5'(DIV_STEPS - 1)) state_next = S_NORM;
      S_NORM:    if (div_valid) state_next = S_ROUND;
      S_ROUND:   state_next = S_IDLE;
      S_SPECIAL: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      cnt_reg      <= '0;
      man_reg      <= '0;
      guard_reg    <= 1'b0;
      sticky_reg   <= 1'b0;
      spec_res_reg <= '0;
      spec_dbz_reg <= 1'b0;
      result_reg   <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      dbz_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sign_reg     <= sign_in;
            exp_reg      <= exp_in;
            spec_res_reg <= spec_res;
            spec_dbz_reg <= spec_dbz;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            dbz_reg      <= 1'b0;
          end
        end
        S_DIV: cnt_reg <= cnt_reg + 5'd1;
        S_NORM: begin
          // A quotient below 1.0 still has its leading one at q[24].
          if (div_valid) begin
            if (div_q[25]) begin
              man_reg    <= div_q[25:2];
              guard_reg  <= div_q[1];
              sticky_reg <= div_sticky | div_q[0];
            end else begin
              man_reg    <= div_q[24:1];
              guard_reg  <= div_q[0];
              sticky_reg <= div_sticky;
              exp_reg    <= exp_reg - 10'sd1;
            end
          end
        end
        S_ROUND: begin
          result_reg <= round_res;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
        end
        S_SPECIAL: begin
          result_reg <= spec_res_reg;
          dbz_reg    <= spec_dbz_reg;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result      = result_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: doc/float_divider.md
# float_divider

Sequential IEEE-754 single-precision divider that computes `a / b`. It is the inverse companion of the pipelined float multiplier and uses the same `start`/`done` handshake, so the two arithmetic blocks can sit side by side in the FP datapath. The mantissa quotient is produced by a multi-cycle restoring divider, one quotient bit per clock. The result is rounded to nearest-even, with denormals flushed to zero.

## Interface
- No parameters; the format is fixed at binary32.
- `clk`  in  1  – system clock; all state updates on the rising edge.
- `rst`  in  1  – reset, asynchronous and active-high.
- `start`  in  1  – one-cycle request; sampled only in IDLE.
- `a`  in  32  – dividend, binary32; sampled on the cycle `start` is accepted.
- `b`  in  32  – divisor, binary32; sampled together with `a`.
- `result`  out  32  – quotient; holds its value until the next completion.
- `done`  out  1  – one-cycle pulse; `result` is valid in the same cycle.
- `busy`  out  1  – high from acceptance until the cycle `done` pulses.
- `div_by_zero`  out  1  – set with `done` when `b` is ±0 and `a` is finite and nonzero; held until the next acceptance.

## Operation
- States:
  - IDLE: `start` → DIV, or SPECIAL if a special case applies.
  - DIV: 26 cycles, then NORM.
  - NORM → ROUND → IDLE.
  - SPECIAL → IDLE.
- Unpack at acceptance:
  - sign = `a[31]` ^ `b[31]`.
  - ma = {1, `a[22:0]`}, mb = {1, `b[22:0]`}.
  - exp = `a[30:23]` − `b[30:23]` + 127, held in a signed 10-bit register.
- Special cases (any operand with exponent 0 counts as zero), in priority order:
  1. Either operand NaN → 0x7FC00000.
  2. inf/inf or 0/0 → 0x7FC00000.
  3. inf/x → signed inf.
  4. x/inf → signed zero.
  5. x/0 → signed inf, with `div_by_zero`.
  6. 0/x → signed zero.
- DIV:
  - Restoring division with a 25-bit partial remainder initialised to ma.
  - Each cycle: if rem ≥ mb, then qbit = 1 and rem −= mb; then rem <<= 1.
  - 26 bits are shifted into q[25:0].
  - sticky = (final rem ≠ 0).
- NORM:
  - If q[25] = 1: man = q[25:2], guard = q[1], sticky |= q[0].
  - Otherwise: man = q[24:1], guard = q[0], and exp −= 1.
- ROUND:
  - Increment man when guard & (sticky | man[0]).
  - If the increment carries out, man = 0x800000 and exp += 1.
  - exp ≥ 255 → signed inf.
  - exp ≤ 0 → signed zero; no denormal output.
  - Otherwise result = {sign, exp[7:0], man[22:0]}.
- `start` while `busy` is ignored; the inputs are not re-sampled.
- Outputs do not depend combinationally on the inputs.

## Timing
- Reset values: `result` = 0, `done` = 0, `busy` = 0, `div_by_zero` = 0, state = IDLE, all datapath registers 0.
- Let edge E0 be the edge that samples `start` = 1 in IDLE.
- Normal path:
  - DIV occupies edges E1–E26, NORM is E27, ROUND is E28.
  - `done` is high for exactly one cycle after E28, so latency is 28 clocks.
- Special path: SPECIAL is E1, and `done` is high after E1 (latency 1).
- `busy` goes high after E0 and low after the edge that raises `done`.
- `start` may be asserted in the cycle `done` is high. It is then in IDLE and is accepted, giving back-to-back operation.
- `rst` asserted mid-operation:
  - All outputs return to their reset values immediately.
  - The operation is discarded and no `done` is issued.

## Structure
- Shared package `fp_pkg`:
  - Field widths: EXP_W = 8, MAN_W = 23, BIAS = 127.
  - Constants: QNAN = 32'h7FC00000, POS_INF = 32'h7F800000.
  - State encoding enum.
  - Classify helpers (is_nan, is_inf, is_zero), also reused by the multiplier.
- One sub-module, `mant_div_seq`:
  - The 26-step restoring mantissa divider.
  - Ports: `load`, ma, mb, `q`, `sticky`, `valid`.
- Top level: FSM, unpack, special-case logic, normalise/round.

## Test plan
- 0x40400000 / 0x40000000 (3.0 / 2.0) → 0x3FC00000; `done` exactly 28 clocks after `start`; `busy` high for 28 cycles.
- 0x3F800000 / 0x40400000 (1.0 / 3.0) → 0x3EAAAAAB, which exercises round-up via guard/sticky. 0xC0E00000 / 0x40000000 (−7 / 2) → 0xC0600000.
- Special cases:
  - 0x3F800000 / 0x00000000 → 0x7F800000 with `div_by_zero` = 1, latency 1.
  - 0 / 0 → 0x7FC00000 with `div_by_zero` = 0.
  - NaN / 1.0 → 0x7FC00000.
- 0x7F000000 / 0x00800000 → 0x7F800000 (overflow). 0x00800000 / 0x7F000000 → 0x00000000 (underflow flush).
- Reset and handshake:
  - Assert `start`, pulse `rst` at cycle 10 → no `done`; outputs are 0 the same cycle.
  - Extra `start` pulses while `busy` do not alter the result.
  - A new `start` asserted in the `done` cycle is accepted and produces a second correct result.
